// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_if
// Description : Requester-side handshake bundle for data_mem_arbiter.
//               master = requester (CPU LSU or debug loader),
//               slave  = arbiter.
//   req   requester -> arbiter   request, held with we/addr/wdata/size until gnt
//   we    requester -> arbiter   1 = write, 0 = read
//   addr  requester -> arbiter   byte address (AW bits)
//   wdata requester -> arbiter   write data (DW bits)
//   size  requester -> arbiter   0 = byte, 1 = halfword
//   gnt   arbiter -> requester   1-cycle pulse, request latched
//   done  arbiter -> requester   1-cycle pulse, access complete
//   rdata arbiter -> requester   read data, held until next done
// Revision    : 1.0  initial release
// ============================================================================
interface data_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          size;
  logic          gnt;
  logic          done;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, size, input gnt, done, rdata);
  modport slave  (input req, we, addr, wdata, size, output gnt, done, rdata);
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Round-robin arbiter sharing the single DataMemory port between
//               port 0 (CPU load/store unit) and port 1 (debug/loader).
//               One latched request -> one memory access -> done pulse.
//               Sequence IDLE -> ACCESS -> DONE, one transaction per 3 cycles.
// Ports       :
//   CLK        in   system clock, all state on posedge
//   RESET      in   asynchronous active-low reset
//   m0, m1     slave modports of data_mem_arbiter_if (requester handshakes)
//   mem_wmem   out  DataMemory wmem, high only during ACCESS of a write
//   mem_addr   out  DataMemory DAddress (latched request address)
//   mem_wdata  out  DataMemory DataIn    (latched write data)
//   mem_memc   out  DataMemory memc      (latched size)
//   mem_rdata  in   DataMemory DataOut   (combinational read)
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  data_mem_arbiter_if.slave m0,
  data_mem_arbiter_if.slave m1,
  output logic              mem_wmem,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_memc,
  input  logic [DW-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;       // port currently being served
  logic          r_last_owner;  // port served most recently (tie-break)
  logic          r_we;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_done0;
  logic          r_done1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_sel_valid;
  logic          w_sel_port;

  // A lone requester wins outright; on a tie the port that did not go last wins.
  always_comb begin
    w_sel_valid = m0.req | m1.req;
    if (m0.req && m1.req) begin
      w_sel_port = ~r_last_owner;
    end else begin
      w_sel_port = m1.req;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;     // port 0 wins the first tie after reset
      r_we         <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      mem_wmem     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_memc     <= 1'b0;
    end else begin
      // gnt and done are single-cycle pulses
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_owner      <= w_sel_port;
            r_last_owner <= w_sel_port;
            r_we         <= w_sel_port ? m1.we    : m0.we;
            mem_wmem     <= w_sel_port ? m1.we    : m0.we;
            mem_addr     <= w_sel_port ? m1.addr  : m0.addr;
            mem_wdata    <= w_sel_port ? m1.wdata : m0.wdata;
            mem_memc     <= w_sel_port ? m1.size  : m0.size;
            r_gnt0       <= ~w_sel_port;
            r_gnt1       <= w_sel_port;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // The write lands on this edge; read data is captured on it too.
          mem_wmem <= 1'b0;
          if (!r_we) begin
            if (r_owner) begin
              r_rdata1 <= mem_rdata;
            end else begin
              r_rdata0 <= mem_rdata;
            end
          end
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m0.gnt   = r_gnt0;
  assign m1.gnt   = r_gnt1;
  assign m0.done  = r_done0;
  assign m1.done  = r_done1;
  assign m0.rdata = r_rdata0;
  assign m1.rdata = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_arbiter
// Description : Self-checking bench for data_mem_arbiter. Provides a byte-wide
//               little-endian DataMemory model and a reference memory image
//               plus round-robin history used to predict every result.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b0;
  logic          mem_wmem;
  logic          mem_memc;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  data_mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
  data_mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

  data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_wmem  (mem_wmem),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_memc  (mem_memc),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  int n_asrt     = 0;
  int n_fail     = 0;
  int last_owner = 1;

  logic [7:0] dmem    [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         mem_ready = 1'b0;

  function automatic logic [7:0] init_byte(input int i);
    logic [31:0] v;
    v = i * 37 + (i >> 8) * 11 + 90;
    return v[7:0];
  endfunction

  // DataMemory model: byte = low byte at addr, halfword = {addr|1, addr&~1}
  assign mem_rdata = mem_memc ? {dmem[mem_addr | 16'h0001], dmem[mem_addr & 16'hFFFE]}
                              : {8'h00, dmem[mem_addr]};

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) dmem[i] = init_byte(i);
      mem_ready = 1'b1;
    end else if (mem_wmem) begin
      if (mem_memc) begin
        dmem[mem_addr & 16'hFFFE] = mem_wdata[7:0];
        dmem[mem_addr | 16'h0001] = mem_wdata[15:8];
      end else begin
        dmem[mem_addr] = mem_wdata[7:0];
      end
    end
  end

  function automatic logic [15:0] ref_rd(input logic [15:0] a, input logic sz);
    if (sz) return {ref_mem[a | 16'h0001], ref_mem[a & 16'hFFFE]};
    return {8'h00, ref_mem[a]};
  endfunction

  task automatic ref_wr(input logic [15:0] a, input logic [15:0] d, input logic sz);
    if (sz) begin
      ref_mem[a & 16'hFFFE] = d[7:0];
      ref_mem[a | 16'h0001] = d[15:8];
    end else begin
      ref_mem[a] = d[7:0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic port_gnt(input int p);
    return (p != 0) ? m1_if.gnt : m0_if.gnt;
  endfunction
  function automatic logic port_done(input int p);
    return (p != 0) ? m1_if.done : m0_if.done;
  endfunction
  function automatic logic [15:0] port_rdata(input int p);
    return (p != 0) ? m1_if.rdata : m0_if.rdata;
  endfunction

  task automatic drive(input int p, input logic rq, input logic we, input logic [15:0] a,
                       input logic [15:0] wd, input logic sz);
    if (p != 0) begin
      m1_if.req = rq; m1_if.we = we; m1_if.addr = a; m1_if.wdata = wd; m1_if.size = sz;
    end else begin
      m0_if.req = rq; m0_if.we = we; m0_if.addr = a; m0_if.wdata = wd; m0_if.size = sz;
    end
  endtask

  // One isolated transaction on port p, checked cycle by cycle.
  task automatic txn(input int p, input logic we, input logic [15:0] a,
                     input logic [15:0] wd, input logic sz, input string tag);
    int          lat;
    int          q;
    logic [15:0] other_rd;
    q        = 1 - p;
    other_rd = port_rdata(q);
    @(posedge CLK); #1;
    drive(p, 1'b1, we, a, wd, sz);
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge CLK);
      if (port_gnt(p)) break;
    end
    chk({tag, " gnt latency"}, lat, 2);
    chk({tag, " access addr"}, mem_addr, a);
    chk({tag, " access memc"}, mem_memc, sz);
    chk({tag, " access wmem"}, mem_wmem, we);
    if (we) chk({tag, " access wdata"}, mem_wdata, wd);
    chk({tag, " other gnt"}, port_gnt(q), 1'b0);
    // request withdrawn and fields scrambled: the latched copy must be used
    drive(p, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    if (we) ref_wr(a, wd, sz);
    last_owner = p;
    @(negedge CLK);
    chk({tag, " done"}, port_done(p), 1'b1);
    chk({tag, " gnt cleared"}, port_gnt(p), 1'b0);
    chk({tag, " wmem in done"}, mem_wmem, 1'b0);
    chk({tag, " other done"}, port_done(q), 1'b0);
    if (!we) chk({tag, " rdata"}, port_rdata(p), ref_rd(a, sz));
    @(negedge CLK);
    chk({tag, " done pulse"}, port_done(p), 1'b0);
    chk({tag, " other rdata kept"}, port_rdata(q), other_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          ngr;
    int          last_c;
    int          exp_p;
    int          gp;
    int          wcount;
    bit          seen_done;
    logic [15:0] a0, a1, d0, d5;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    chk("reset mem_wmem",  mem_wmem, 1'b0);
    chk("reset mem_addr",  mem_addr, 16'h0);
    chk("reset mem_wdata", mem_wdata, 16'h0);
    chk("reset mem_memc",  mem_memc, 1'b0);
    chk("reset gnt/done",  {m0_if.gnt, m0_if.done, m1_if.gnt, m1_if.done}, 4'b0);
    chk("reset m0 rdata",  m0_if.rdata, 16'h0);
    chk("reset m1 rdata",  m1_if.rdata, 16'h0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("idle no gnt", {m0_if.gnt, m1_if.gnt}, 2'b0);

    // ---- halfword write then halfword/byte reads ----
    txn(0, 1'b1, 16'h1000, 16'hBEEF, 1'b1, "t1 m0 write");
    chk("t1 m1 rdata untouched", m1_if.rdata, 16'h0);
    txn(0, 1'b0, 16'h1000, 16'h0000, 1'b1, "t2 m0 read hw");
    chk("t2 hw value", m0_if.rdata, 16'hBEEF);
    txn(0, 1'b0, 16'h1000, 16'h0000, 1'b0, "t2 m0 read byte");
    chk("t2 byte value", m0_if.rdata, 16'h00EF);

    // ---- port 1 read from low memory ----
    txn(1, 1'b0, 16'h0004, 16'h0000, 1'b1, "t6 m1 read");

    // ---- both ports requesting continuously ----
    a0 = 16'h4000; a1 = 16'h0100; d0 = 16'($urandom);
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, a0, d0, 1'b1);
    drive(1, 1'b1, 1'b0, a1, 16'h0, 1'b1);
    ngr = 0; last_c = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (m1_if.done) chk("t3 m1 rdata", m1_if.rdata, ref_rd(a1, 1'b1));
      if (m0_if.gnt || m1_if.gnt) begin
        gp    = m1_if.gnt ? 1 : 0;
        exp_p = 1 - last_owner;
        chk("t3 single gnt", {m0_if.gnt, m1_if.gnt} == 2'b11, 1'b0);
        chk("t3 grant port", gp, exp_p);
        if (ngr > 0) chk("t3 grant spacing", c - last_c, 3);
        chk("t3 access addr", mem_addr, (gp != 0) ? a1 : a0);
        chk("t3 access wmem", mem_wmem, (gp == 0));
        if (gp == 0) ref_wr(a0, d0, 1'b1);
        last_owner = gp;
        last_c     = c;
        ngr++;
      end
    end
    chk("t3 grant count", ngr, 7);
    drive(0, 1'b0, 1'b0, a0, d0, 1'b1);
    drive(1, 1'b0, 1'b0, a1, 16'h0, 1'b1);
    repeat (3) @(negedge CLK);

    // ---- port 1 write blocks a later port 0 request ----
    @(posedge CLK); #1;
    drive(1, 1'b1, 1'b1, 16'h2000, 16'h0001, 1'b1);
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge CLK);
      if (m1_if.gnt) break;
    end
    chk("t4 m1 gnt latency", lat, 2);
    chk("t4 m1 access addr", mem_addr, 16'h2000);
    drive(0, 1'b1, 1'b0, 16'h2000, 16'h0, 1'b1);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    ref_wr(16'h2000, 16'h0001, 1'b1);
    last_owner = 1;
    wcount     = int'(mem_wmem);
    seen_done  = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge CLK);
      if (m1_if.done) seen_done = 1'b1;
      if (m0_if.gnt) break;
      wcount += int'(mem_wmem);
    end
    chk("t4 m0 gnt after m1 done", seen_done, 1'b1);
    chk("t4 m0 gnt delay", lat, 3);
    chk("t4 write pulse count", wcount, 1);
    chk("t4 m0 access wmem", mem_wmem, 1'b0);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    last_owner = 0;
    @(negedge CLK);
    chk("t4 m0 done", m0_if.done, 1'b1);
    chk("t4 m0 rdata", m0_if.rdata, 16'h0001);
    @(negedge CLK);

    // ---- reset in the middle of a write access ----
    d5 = 16'($urandom) ^ ref_rd(16'h3000, 1'b1) ^ 16'h0101;
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 16'h3000, d5, 1'b1);
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge CLK);
      if (m0_if.gnt) break;
    end
    chk("t5 gnt latency", lat, 2);
    chk("t5 wmem before reset", mem_wmem, 1'b1);
    RESET = 1'b0;
    #1;
    chk("t5 wmem dropped", mem_wmem, 1'b0);
    chk("t5 gnt dropped", m0_if.gnt, 1'b0);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) begin
      @(negedge CLK);
      chk("t5 no done", {m0_if.done, m1_if.done}, 2'b0);
    end
    chk("t5 memory unchanged", {dmem[16'h3001], dmem[16'h3000]}, ref_rd(16'h3000, 1'b1));
    chk("t5 m0 rdata cleared", m0_if.rdata, 16'h0);
    RESET = 1'b1;
    last_owner = 1;
    txn(0, 1'b0, 16'h3000, 16'h0, 1'b1, "t5 read after reset");

    // ---- randomized isolated transactions ----
    for (int k = 0; k < 16; k++) begin
      txn(int'($urandom_range(1, 0)), 1'($urandom), 16'($urandom),
          16'($urandom), 1'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
